// File: rtl/zion_pipe_flush_ctrl.sv
// Handshake and clear sequencer for a STAGES-deep pipeline of clear-capable data registers.
// Items shift forward on per-stage load enables, bubbles collapse, and a flush empties the pipe and holds clear.
module zion_pipe_flush_ctrl #(
  parameter int STAGES    = 4,
  parameter int FLUSH_CYC = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            iVld,
  output logic                            oRdy,
  output logic                            oVld,
  input  logic                            iRdy,
  input  logic                            iFlush,
  output logic [STAGES-1:0]               oEn,
  output logic [STAGES-1:0]               oClr,
  output logic [STAGES-1:0]               oStgVld,
  output logic [$clog2(STAGES+1)-1:0]     oCnt,
  output logic                            oBusy
);

  localparam int CW = $clog2(STAGES+1);
  localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYC);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t            state;
  logic [STAGES-1:0] stg_vld;
  logic [STAGES-1:0] clr_q;
  logic [CW-1:0]     cnt;
  logic [3:0]        fcnt;

  logic              block;
  logic              lv;
  logic [STAGES:0]   src_all;
  logic [STAGES-1:0] en;
  logic [STAGES-1:0] leave;
  logic [STAGES-1:0] vld_nxt;

  function automatic logic [CW-1:0] popcount(input logic [STAGES-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (v[i]) c = c + CW'(1);
    end
    return c;
  endfunction

  // Enables resolve from the output end backwards: a stage may take its source when it is empty or drained this cycle.
  always_comb begin
    block   = !rst || iFlush || (state == FLUSH);
    src_all = {stg_vld, iVld};
    en      = '0;
    leave   = '0;
    lv      = !block && stg_vld[STAGES-1] && iRdy;
    for (int k = STAGES-1; k >= 0; k--) begin
      leave[k] = lv;
      en[k]    = !block && src_all[k] && (!stg_vld[k] || lv);
      lv       = en[k];
    end
    vld_nxt = (stg_vld & ~leave) | en;
  end

  assign oRdy    = !block && (!stg_vld[0] || leave[0]);
  assign oVld    = !block && stg_vld[STAGES-1];
  assign oEn     = en;
  assign oClr    = clr_q | {STAGES{!rst}};
  assign oStgVld = stg_vld;
  assign oCnt    = cnt;
  assign oBusy   = (state == FLUSH);

  // State register: flush wins over everything, then occupancy advances.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      stg_vld <= '0;
      cnt     <= '0;
      fcnt    <= '0;
      clr_q   <= '0;
    end else if (iFlush) begin
      state   <= FLUSH;
      fcnt    <= FLUSH_LD;
      stg_vld <= '0;
      cnt     <= '0;
      clr_q   <= '1;
    end else begin
      case (state)
        FLUSH: begin
          if (fcnt <= 4'd1) begin
            state <= IDLE;
            fcnt  <= '0;
            clr_q <= '0;
          end else begin
            fcnt  <= fcnt - 4'd1;
            clr_q <= '1;
          end
        end
        default: begin
          stg_vld <= vld_nxt;
          cnt     <= popcount(vld_nxt);
          clr_q   <= leave & ~en;
          state   <= (|vld_nxt) ? RUN : IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/zion_pipe_flush_ctrl.md
ZION_PIPE_FLUSH_CTRL -- requirements
Module: zion_pipe_flush_ctrl

Interface
- REQ-001: STAGES, default 4, number of clear-capable pipeline data registers sequenced; legal 1..16.
- REQ-002: FLUSH_CYC, default 2, number of cycles the flush clear is held; legal 1..15.
- REQ-003: clk  input  1  single clock; all state updates on posedge clk.
- REQ-004: rst  input  1  reset, asynchronous, active-low.
- REQ-005: iVld  input  1  upstream data valid.
- REQ-006: oRdy  output  1  upstream ready; transfer when iVld && oRdy.
- REQ-007: oVld  output  1  downstream valid, stage STAGES-1 occupied.
- REQ-008: iRdy  input  1  downstream ready; transfer when oVld && iRdy.
- REQ-009: iFlush  input  1  flush request, active high, single-cycle or level.
- REQ-010: oEn  output  STAGES  per-stage data load enable, bit k loads stage k.
- REQ-011: oClr  output  STAGES  per-stage clear, drives the clear input of the data registers.
- REQ-012: oStgVld  output  STAGES  per-stage occupancy flag.
- REQ-013: oCnt  output  $clog2(STAGES+1)  number of occupied stages.
- REQ-014: oBusy  output  1  high in FLUSH state.

Function
- REQ-015: FSM states IDLE (no stage occupied), RUN (at least one occupied), FLUSH.
- REQ-016: IDLE->RUN on an upstream transfer; RUN->IDLE when the last occupied item leaves and none enters; any state->FLUSH on iFlush=1.
- REQ-017: FLUSH lasts exactly FLUSH_CYC cycles counted by an internal down-counter, then goes to IDLE; iFlush=1 while in FLUSH reloads the counter.
- REQ-018: Stage k accepts (oEn[k]=1) when its source is valid and stage k is empty or its content leaves this cycle; source of stage 0 is upstream transfer, of stage k>0 is stage k-1.
- REQ-019: Stage STAGES-1 leaves on downstream transfer; stage k<STAGES-1 leaves when stage k+1 accepts.
- REQ-020: Bubbles collapse: an empty stage accepts regardless of downstream state.
- REQ-021: oRdy = !oStgVld[0] or stage 0 leaves, forced 0 in FLUSH and whenever iFlush=1.
- REQ-022: oVld = oStgVld[STAGES-1], forced 0 in FLUSH and whenever iFlush=1.
- REQ-023: oEn all 0 in FLUSH and whenever iFlush=1.
- REQ-024: Latency: item accepted in cycle t into an empty pipe is presented on oVld in cycle t+STAGES; throughput one item per cycle with iRdy=1.
- REQ-025: oStgVld[k] updates next cycle: set on accept, cleared on leave without accept, held otherwise.
- REQ-026: Cycle after iFlush=1: all oStgVld=0, oCnt=0, oClr all ones; oClr stays all ones for FLUSH_CYC cycles, then 0.
- REQ-027: Outside FLUSH, oClr[k]=1 only in the cycle after stage k leaves without accepting (clears stale data), else 0.
- REQ-028: oCnt equals the popcount of oStgVld every cycle; never exceeds STAGES.
- REQ-029: Simultaneous upstream and downstream transfer with full pipe: all stages shift, oCnt unchanged.
- REQ-030: Simultaneous iFlush and iVld/iRdy: no transfer occurs on either side; flush takes priority.

Reset
- REQ-031: rst=0 asynchronously forces IDLE, oStgVld=0, oCnt=0, oBusy=0, oVld=0, oEn=0, flush counter=0.
- REQ-032: During reset oClr all ones and oRdy=0; after release oClr=0 and oRdy=1 in the first cycle.
- REQ-033: Reset asserted mid-FLUSH or mid-stream discards all state; no item is presented after release until newly accepted.

Verification (STAGES=4, FLUSH_CYC=2)
- REQ-034: Empty pipe, iVld=1 one cycle at t0, iRdy=1 -> oVld=1 at t0+4 for one cycle, oCnt 1 during t0+1..t0+4.
- REQ-035: iVld=1 continuous, iRdy=0 -> oRdy drops after 4 accepts, oCnt=4; iRdy=1 then -> one item per cycle, oRdy=1 each cycle.
- REQ-036: Items at stages 0 and 3 only, iRdy=0 -> stage 0 item advances to stage 2 in 2 cycles, oCnt stays 2.
- REQ-037: oCnt=3, iFlush=1 with iVld=iRdy=1 -> no transfers that cycle; next cycle oCnt=0, oClr=4'b1111, oBusy=1 for 2 cycles, then IDLE, oRdy=1.
- REQ-038: iFlush pulsed again in second FLUSH cycle -> FLUSH extends to 2 cycles after the second pulse.
- REQ-039: rst=0 asserted mid-stream with oCnt=4 -> outputs reset immediately without clock; after release oVld=0 until a new item traverses 4 stages.
